// File: rtl/lock_sequencer_if.sv
// Board-side signal bundle for the lock sequencer: button/switch inputs and lock status outputs.
interface lock_if #(
    parameter int unsigned CODE_W = 8
);
    logic              ok;
    logic              mode;
    logic [CODE_W-1:0] switch;
    logic              unlocked;
    logic              alarm;
    logic              bad_digit;
    logic              code_changed;
    logic [3:0]        fail_cnt;

    modport master (
        output ok, mode, switch,
        input  unlocked, alarm, bad_digit, code_changed, fail_cnt
    );

    modport slave (
        input  ok, mode, switch,
        output unlocked, alarm, bad_digit, code_changed, fail_cnt
    );
endinterface

// File: rtl/lock_sequencer.sv
// Single-clock digital lock controller: code entry, unlock, code change, lockout and auto-relock.
// Optional macro CONFIRM_CODE_EN: a code change needs two matching mode=1 presses.
module lock_sequencer #(
    parameter int unsigned      CODE_W      = 8,
    parameter logic [CODE_W-1:0] RESET_CODE = CODE_W'(8'h13),
    parameter int unsigned      MAX_TRIES   = 3,
    parameter int unsigned      LOCKOUT_CYC = 1000,
    parameter int unsigned      RELOCK_CYC  = 5000
) (
    input logic   clk,
    input logic   reset,
    lock_if.slave lk
);
    localparam int unsigned NIBBLES  = CODE_W / 4;
    localparam int unsigned LOCK_W   = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    localparam int unsigned RELOCK_W = (RELOCK_CYC > 1) ? $clog2(RELOCK_CYC) : 1;
    localparam logic [LOCK_W-1:0]   LOCK_LAST   = LOCK_W'(LOCKOUT_CYC - 1);
    localparam logic [RELOCK_W-1:0] RELOCK_LAST = RELOCK_W'(RELOCK_CYC - 1);
    localparam logic [3:0]          TRIES       = 4'(MAX_TRIES);

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          sync_q, sync_d;
    logic                ok_pulse_q, ok_pulse_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [3:0]          fail_q, fail_d;
    logic [LOCK_W-1:0]   lock_tmr_q, lock_tmr_d;
    logic [RELOCK_W-1:0] relock_tmr_q, relock_tmr_d;
    logic                unlocked_q, unlocked_d;
    logic                alarm_q, alarm_d;
    logic                bad_q, bad_d;
    logic                chg_q, chg_d;
`ifdef CONFIRM_CODE_EN
    logic                pending_q, pending_d;
    logic [CODE_W-1:0]   pending_code_q, pending_code_d;
`endif

    // True when any BCD nibble of the switch value exceeds 9.
    function automatic logic has_bad_digit(input logic [CODE_W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Two-stage synchronizer, history flop, and registered rising-edge pulse.
    always_comb begin
        sync_d     = {sync_q[1:0], lk.ok};
        ok_pulse_d = sync_q[1] & ~sync_q[2];
    end

    always_comb begin
        state_d        = state_q;
        code_d         = code_q;
        fail_d         = fail_q;
        lock_tmr_d     = lock_tmr_q;
        relock_tmr_d   = relock_tmr_q;
        bad_d          = 1'b0;
        chg_d          = 1'b0;
`ifdef CONFIRM_CODE_EN
        pending_d      = pending_q;
        pending_code_d = pending_code_q;
`endif
        case (state_q)
            ST_LOCKED: begin
                if (ok_pulse_q) begin
                    if (has_bad_digit(lk.switch)) begin
                        bad_d = 1'b1;
                    end else if (lk.switch == code_q) begin
                        state_d      = ST_OPEN;
                        fail_d       = 4'd0;
                        relock_tmr_d = '0;
                    end else begin
                        if (fail_q < TRIES) fail_d = fail_q + 4'd1;
                        if (fail_q + 4'd1 >= TRIES) begin
                            state_d    = ST_LOCKOUT;
                            lock_tmr_d = '0;
                        end
                    end
                end
            end
            ST_OPEN: begin
                // A press always beats the relock timeout in the same cycle.
                if (ok_pulse_q) begin
                    relock_tmr_d = '0;
                    if (has_bad_digit(lk.switch)) begin
                        bad_d = 1'b1;
                    end else if (!lk.mode) begin
                        state_d = ST_LOCKED;
`ifdef CONFIRM_CODE_EN
                        pending_d = 1'b0;
`endif
                    end else begin
`ifdef CONFIRM_CODE_EN
                        if (!pending_q) begin
                            pending_d      = 1'b1;
                            pending_code_d = lk.switch;
                        end else begin
                            pending_d = 1'b0;
                            if (lk.switch == pending_code_q) begin
                                code_d = lk.switch;
                                chg_d  = 1'b1;
                            end else begin
                                bad_d = 1'b1;
                            end
                        end
`else
                        code_d = lk.switch;
                        chg_d  = 1'b1;
`endif
                    end
                end else if (relock_tmr_q == RELOCK_LAST) begin
                    state_d = ST_LOCKED;
                end else begin
                    relock_tmr_d = relock_tmr_q + RELOCK_W'(1);
                end
            end
            ST_LOCKOUT: begin
                if (lock_tmr_q == LOCK_LAST) begin
                    state_d = ST_LOCKED;
                    fail_d  = 4'd0;
                end else begin
                    lock_tmr_d = lock_tmr_q + LOCK_W'(1);
                end
            end
            default: begin
                state_d = ST_LOCKED;
            end
        endcase
`ifdef CONFIRM_CODE_EN
        if (state_d != ST_OPEN) pending_d = 1'b0;
`endif
        unlocked_d = (state_d == ST_OPEN);
        alarm_d    = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_LOCKED;
            sync_q         <= '0;
            ok_pulse_q     <= 1'b0;
            code_q         <= RESET_CODE;
            fail_q         <= 4'd0;
            lock_tmr_q     <= '0;
            relock_tmr_q   <= '0;
            unlocked_q     <= 1'b0;
            alarm_q        <= 1'b0;
            bad_q          <= 1'b0;
            chg_q          <= 1'b0;
`ifdef CONFIRM_CODE_EN
            pending_q      <= 1'b0;
            pending_code_q <= '0;
`endif
        end else begin
            state_q        <= state_d;
            sync_q         <= sync_d;
            ok_pulse_q     <= ok_pulse_d;
            code_q         <= code_d;
            fail_q         <= fail_d;
            lock_tmr_q     <= lock_tmr_d;
            relock_tmr_q   <= relock_tmr_d;
            unlocked_q     <= unlocked_d;
            alarm_q        <= alarm_d;
            bad_q          <= bad_d;
            chg_q          <= chg_d;
`ifdef CONFIRM_CODE_EN
            pending_q      <= pending_d;
            pending_code_q <= pending_code_d;
`endif
        end
    end

    assign lk.unlocked     = unlocked_q;
    assign lk.alarm        = alarm_q;
    assign lk.bad_digit    = bad_q;
    assign lk.code_changed = chg_q;
    assign lk.fail_cnt     = fail_q;
endmodule
